// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU command driver:
//   ALU_W / OP_W / RSP_W : operand, opcode and {extra, out} result widths
//   DEF_TAG_W            : default command/response tag width
//   alu_rsp_t            : one response entry {extra, out, op, tag} at the
//                          default tag width
//   state_t              : driver FSM states
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W     = 4;
    localparam int OP_W      = 2;
    localparam int RSP_W     = ALU_W + 1;
    localparam int DEF_TAG_W = 4;

    typedef struct packed {
        logic                 extra;
        logic [ALU_W-1:0]     out;
        logic [OP_W-1:0]      op;
        logic [DEF_TAG_W-1:0] tag;
    } alu_rsp_t;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver_if
// Bundles the three buses of the ALU command driver:
//   cmd_*  : valid/ready command stream from the host
//   alu_*  : operand/opcode drive to alu_machine and its result back
//   rsp_*  : valid/ready response stream to the host
// modport master : host/environment view (drives commands, ALU result)
// modport slave  : driver view (alu_cmd_driver)
// -----------------------------------------------------------------------------
interface alu_cmd_driver_if #(
    parameter int TAG_W = alu_pkg::DEF_TAG_W
);
    import alu_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ALU_W-1:0]     cmd_a;
    logic [ALU_W-1:0]     cmd_b;
    logic [OP_W-1:0]      cmd_op;
    logic [TAG_W-1:0]     cmd_tag;

    logic [ALU_W-1:0]     alu_a;
    logic [ALU_W-1:0]     alu_b;
    logic [OP_W-1:0]      alu_op;
    logic [ALU_W-1:0]     alu_out;
    logic                 alu_extra;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [RSP_W-1:0]     rsp_data;
    logic [OP_W-1:0]      rsp_op;
    logic [TAG_W-1:0]     rsp_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready, alu_out, alu_extra,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_op, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready, alu_out, alu_extra,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_op, rsp_tag
    );

endinterface

// File: rtl/alu_rsp_fifo.sv
// -----------------------------------------------------------------------------
// alu_rsp_fifo
// Synchronous first-word-fall-through FIFO with occupancy count.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write data_i (ignored when full)
//   data_i    : write data
//   pop_i     : consume the head entry (ignored when empty)
//   valid_o   : FIFO not empty
//   data_o    : head entry, reads 0 while empty
//   count_o   : number of stored entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module alu_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("alu_rsp_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only visible through valid_o,
    // and the output mux below forces zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver
// Initiator for the combinational 4-bit alu_machine. Accepts one command at a
// time, holds the operands on alu_* for SETTLE_CYCLES cycles, samples
// {alu_extra, alu_out} and queues it with opcode and tag in a response FIFO.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : cmd_* stream in, alu_* drive/result, rsp_* stream out
//   busy_o         : a command is in flight (WAIT)
//   done_count_o   : completed operations, saturating
//   extra_count_o  : completed operations with extra=1, saturating
// A command is accepted only when a FIFO slot is free, so pushes never drop.
// -----------------------------------------------------------------------------
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int RSP_DEPTH     = 2,
    parameter int TAG_W         = DEF_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    alu_cmd_driver_if.slave bus,
    output logic        busy_o,
    output logic [15:0] done_count_o,
    output logic [15:0] extra_count_o
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    // settle counter only has to hold SETTLE_CYCLES-1
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("alu_cmd_driver: SETTLE_CYCLES must be >= 1");
    end

    typedef struct packed {
        logic             extra;
        logic [ALU_W-1:0] out;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    state_t           state_q;
    logic [SW-1:0]    settle_q;
    logic [ALU_W-1:0] alu_a_q;
    logic [ALU_W-1:0] alu_b_q;
    logic [OP_W-1:0]  alu_op_q;
    logic [TAG_W-1:0] tag_q;
    logic [15:0]      done_q;
    logic [15:0]      extra_q;

    logic             cmd_ready;
    logic             accept;
    logic             push;
    rsp_t             push_data;
    rsp_t             pop_data;
    logic             fifo_valid;
    logic [CW-1:0]    fifo_count;

    // NOTE: every always_comb output is assigned on every path (here
    // unconditionally) so no latch is inferred.
    always_comb begin
        cmd_ready = (state_q == IDLE) && (fifo_count < CW'(RSP_DEPTH));
        accept    = cmd_ready && bus.cmd_valid;
        push      = (state_q == WAIT) && (settle_q == '0);
        push_data = '{extra: bus.alu_extra, out: bus.alu_out, op: alu_op_q, tag: tag_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            tag_q    <= '0;
            done_q   <= '0;
            extra_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q  <= bus.cmd_a;
                        alu_b_q  <= bus.cmd_b;
                        alu_op_q <= bus.cmd_op;
                        tag_q    <= bus.cmd_tag;
                        settle_q <= SW'(SETTLE_CYCLES - 1);
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - SW'(1);
                    end else begin
                        // result sampled this edge; the FIFO push is 'push'
                        state_q <= IDLE;
                        if (done_q != '1) done_q <= done_q + 16'd1;
                        if (bus.alu_extra && (extra_q != '1)) extra_q <= extra_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    alu_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (bus.rsp_ready),
        .valid_o (fifo_valid),
        .data_o  (pop_data),
        .count_o (fifo_count)
    );

    assign bus.cmd_ready = cmd_ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = fifo_valid;
    assign bus.rsp_data  = {pop_data.extra, pop_data.out};
    assign bus.rsp_op    = pop_data.op;
    assign bus.rsp_tag   = pop_data.tag;

    assign busy_o        = (state_q == WAIT);
    assign done_count_o  = done_q;
    assign extra_count_o = extra_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_driver
// Two drivers: dut1 with SETTLE_CYCLES=1 for the stream tests, dut4 with
// SETTLE_CYCLES=4 for latency and reset-during-WAIT. alu_machine is stubbed
// as {Extra,Out} = A + B + OP. dut1 responses are checked against a queue of
// expected entries pushed at command accept.
// -----------------------------------------------------------------------------
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy1, busy4;
    logic [15:0] done1, extra1, done4, extra4;

    int vectors     = 0;
    int miscompares = 0;

    alu_rsp_t exp_q[$];
    alu_rsp_t mon_got;
    alu_rsp_t mon_exp;

    always #5 clk = ~clk;

    alu_cmd_driver_if #(.TAG_W(DEF_TAG_W)) bus1();
    alu_cmd_driver_if #(.TAG_W(DEF_TAG_W)) bus4();

    alu_cmd_driver #(.SETTLE_CYCLES(1), .RSP_DEPTH(2), .TAG_W(DEF_TAG_W)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .busy_o(busy1), .done_count_o(done1), .extra_count_o(extra1)
    );

    alu_cmd_driver #(.SETTLE_CYCLES(4), .RSP_DEPTH(2), .TAG_W(DEF_TAG_W)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .busy_o(busy4), .done_count_o(done4), .extra_count_o(extra4)
    );

    // alu_machine stubs
    assign {bus1.alu_extra, bus1.alu_out} = 5'(bus1.alu_a) + 5'(bus1.alu_b) + 5'(bus1.alu_op);
    assign {bus4.alu_extra, bus4.alu_out} = 5'(bus4.alu_a) + 5'(bus4.alu_b) + 5'(bus4.alu_op);

    function automatic alu_rsp_t model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op, input logic [3:0] tag);
        alu_rsp_t   r;
        logic [4:0] s;
        s       = 5'(a) + 5'(b) + 5'(op);
        r.extra = s[4];
        r.out   = s[3:0];
        r.op    = op;
        r.tag   = tag;
        return r;
    endfunction

    // dut1 response scoreboard: a handshake seen at negedge completes at the next posedge
    always @(negedge clk) begin
        if (!rst && bus1.rsp_valid && bus1.rsp_ready) begin
            mon_got = {bus1.rsp_data, bus1.rsp_op, bus1.rsp_tag};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected got=%h", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL rsp_entry got={x%0b,d%0d,op%0d,tag%0d} exp={x%0b,d%0d,op%0d,tag%0d}",
                             mon_got.extra, mon_got.out, mon_got.op, mon_got.tag,
                             mon_exp.extra, mon_exp.out, mon_exp.op, mon_exp.tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command on dut1 until accepted; returns the accept edge time.
    task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                            input logic [3:0] tag, output time t_acc);
        bit acc;
        acc = 1'b0;
        t_acc = 0;
        bus1.cmd_a = a; bus1.cmd_b = b; bus1.cmd_op = op; bus1.cmd_tag = tag;
        bus1.cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus1.cmd_ready) begin
                acc = 1'b1;
                break;
            end
            tick();
        end
        if (acc) begin
            @(posedge clk);
            t_acc = $time;
            #1;
            exp_q.push_back(model(a, b, op, tag));
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout tag=%0d", tag);
        end
        bus1.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bus1.rsp_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        vectors++;
        if (exp_q.size() != 0 || bus1.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain left=%0d rsp_valid=%b exp 0/0", exp_q.size(), bus1.rsp_valid);
        end
        bus1.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors += 10;
        if (bus1.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready got=%b exp=1", bus1.cmd_ready); end
        if (bus1.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got=%b exp=0", bus1.rsp_valid); end
        if (busy1 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy1); end
        if (bus1.alu_a !== 4'd0) begin miscompares++; $display("FAIL rst_alu_a got=%0d exp=0", bus1.alu_a); end
        if (bus1.alu_b !== 4'd0) begin miscompares++; $display("FAIL rst_alu_b got=%0d exp=0", bus1.alu_b); end
        if (bus1.alu_op !== 2'd0) begin miscompares++; $display("FAIL rst_alu_op got=%0d exp=0", bus1.alu_op); end
        if (done1 !== 16'd0) begin miscompares++; $display("FAIL rst_done got=%0d exp=0", done1); end
        if (extra1 !== 16'd0) begin miscompares++; $display("FAIL rst_extra got=%0d exp=0", extra1); end
        if ({bus1.rsp_data, bus1.rsp_op, bus1.rsp_tag} !== 11'd0) begin
            miscompares++; $display("FAIL rst_rsp_fields got=%h exp=0", {bus1.rsp_data, bus1.rsp_op, bus1.rsp_tag});
        end
        if (bus4.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst4_cmd_ready got=%b exp=1", bus4.cmd_ready); end
    endtask

    task automatic test_single_op();
        time t;
        send_cmd(4'd3, 4'd4, 2'd0, 4'd1, t);
        vectors += 3;
        if (bus1.alu_a !== 4'd3) begin miscompares++; $display("FAIL single_alu_a got=%0d exp=3", bus1.alu_a); end
        if (busy1 !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", busy1); end
        if (bus1.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid got=%b exp=0", bus1.rsp_valid); end
        tick();
        vectors += 5;
        if (bus1.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_rsp_valid got=%b exp=1", bus1.rsp_valid); end
        if (bus1.rsp_data !== 5'd7) begin miscompares++; $display("FAIL single_rsp_data got=%0d exp=7", bus1.rsp_data); end
        if (bus1.rsp_tag !== 4'd1) begin miscompares++; $display("FAIL single_rsp_tag got=%0d exp=1", bus1.rsp_tag); end
        if (done1 !== 16'd1) begin miscompares++; $display("FAIL single_done got=%0d exp=1", done1); end
        if (extra1 !== 16'd0) begin miscompares++; $display("FAIL single_extra got=%0d exp=0", extra1); end
        drain();
    endtask

    task automatic test_extra_bit();
        time t;
        send_cmd(4'd10, 4'd10, 2'd3, 4'd2, t);
        tick();
        vectors += 3;
        if (bus1.rsp_data !== 5'b10111) begin miscompares++; $display("FAIL extra_rsp_data got=%0d exp=23", bus1.rsp_data); end
        if (extra1 !== 16'd1) begin miscompares++; $display("FAIL extra_count got=%0d exp=1", extra1); end
        if (done1 !== 16'd2) begin miscompares++; $display("FAIL extra_done got=%0d exp=2", done1); end
        drain();
    endtask

    task automatic test_backpressure();
        time t;
        bus1.rsp_ready = 1'b0;
        send_cmd(4'd1, 4'd2, 2'd0, 4'd0, t);
        send_cmd(4'd2, 4'd2, 2'd1, 4'd1, t);
        // third command offered while both FIFO slots will be occupied
        bus1.cmd_a = 4'd5; bus1.cmd_b = 4'd6; bus1.cmd_op = 2'd2; bus1.cmd_tag = 4'd2;
        bus1.cmd_valid = 1'b1;
        tick();
        tick();
        tick();
        vectors += 5;
        if (bus1.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_cmd_ready_full got=%b exp=0", bus1.cmd_ready); end
        if (busy1 !== 1'b0) begin miscompares++; $display("FAIL bp_busy got=%b exp=0", busy1); end
        if (bus1.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_rsp_valid got=%b exp=1", bus1.rsp_valid); end
        if (bus1.rsp_tag !== 4'd0) begin miscompares++; $display("FAIL bp_head_tag got=%0d exp=0", bus1.rsp_tag); end
        if (bus1.alu_a !== 4'd2) begin miscompares++; $display("FAIL bp_alu_hold got=%0d exp=2", bus1.alu_a); end
        // one pop frees a slot
        bus1.rsp_ready = 1'b1;
        tick();
        bus1.rsp_ready = 1'b0;
        vectors++;
        if (bus1.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bp_cmd_ready_freed got=%b exp=1", bus1.cmd_ready); end
        send_cmd(4'd5, 4'd6, 2'd2, 4'd2, t);
        drain();
    endtask

    task automatic test_back_to_back();
        time t0, t1;
        bus1.rsp_ready = 1'b1;
        send_cmd(4'd9, 4'd2, 2'd2, 4'd3, t0);
        send_cmd(4'd0, 4'd5, 2'd1, 4'd4, t1);
        vectors++;
        if (t1 - t0 != 20) begin miscompares++; $display("FAIL b2b_accept_spacing got=%0t exp=20", t1 - t0); end
        drain();
        vectors += 2;
        if (done1 !== 16'd7) begin miscompares++; $display("FAIL b2b_done got=%0d exp=7", done1); end
        if (extra1 !== 16'd1) begin miscompares++; $display("FAIL b2b_extra got=%0d exp=1", extra1); end
    endtask

    task automatic test_settle4_reset();
        bus4.rsp_ready = 1'b0;
        bus4.cmd_a = 4'd7; bus4.cmd_b = 4'd8; bus4.cmd_op = 2'd1; bus4.cmd_tag = 4'd6;
        bus4.cmd_valid = 1'b1;
        tick();
        bus4.cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if (bus4.rsp_valid !== (k == 4)) begin
                miscompares++; $display("FAIL s4_latency cycle=%0d got=%b exp=%b", k, bus4.rsp_valid, (k == 4));
            end
        end
        vectors += 3;
        if (bus4.rsp_data !== 5'b10000) begin miscompares++; $display("FAIL s4_rsp_data got=%0d exp=16", bus4.rsp_data); end
        if (bus4.rsp_tag !== 4'd6) begin miscompares++; $display("FAIL s4_rsp_tag got=%0d exp=6", bus4.rsp_tag); end
        if (extra4 !== 16'd1) begin miscompares++; $display("FAIL s4_extra got=%0d exp=1", extra4); end
        bus4.rsp_ready = 1'b1;
        tick();
        bus4.rsp_ready = 1'b0;
        // second command, reset while it is settling
        bus4.cmd_a = 4'd1; bus4.cmd_b = 4'd1; bus4.cmd_op = 2'd0; bus4.cmd_tag = 4'd7;
        bus4.cmd_valid = 1'b1;
        tick();
        bus4.cmd_valid = 1'b0;
        tick();
        vectors++;
        if (busy4 !== 1'b1) begin miscompares++; $display("FAIL s4_busy_mid got=%b exp=1", busy4); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors += 5;
        if (busy4 !== 1'b0) begin miscompares++; $display("FAIL s4_rst_busy got=%b exp=0", busy4); end
        if (bus4.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL s4_rst_rsp_valid got=%b exp=0", bus4.rsp_valid); end
        if (bus4.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL s4_rst_cmd_ready got=%b exp=1", bus4.cmd_ready); end
        if (done4 !== 16'd0) begin miscompares++; $display("FAIL s4_rst_done got=%0d exp=0", done4); end
        if (bus4.alu_a !== 4'd0) begin miscompares++; $display("FAIL s4_rst_alu_a got=%0d exp=0", bus4.alu_a); end
        for (int k = 0; k < 6; k++) tick();
        vectors++;
        if (bus4.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL s4_late_rsp got=%b exp=0", bus4.rsp_valid); end
    endtask

    initial begin
        rst = 1'b1;
        bus1.cmd_valid = 1'b0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.cmd_op = '0; bus1.cmd_tag = '0;
        bus1.rsp_ready = 1'b0;
        bus4.cmd_valid = 1'b0; bus4.cmd_a = '0; bus4.cmd_b = '0; bus4.cmd_op = '0; bus4.cmd_tag = '0;
        bus4.rsp_ready = 1'b0;

        test_reset();
        test_single_op();
        test_extra_bit();
        test_backpressure();
        test_back_to_back();
        test_settle4_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
